seven_seg_capture: RTL
======================

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter INVERT_SEG, default 1: segment inputs are active-low when 1, active-high when 0.
REQ-002 Parameter INVERT_SEL, default 1: digit-select inputs are active-low when 1, active-high when 0.
REQ-003 Parameter NUM_DIGITS, default 4: number of multiplexed digits captured (legal range 1..8).
REQ-004 Parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 seg_in  input  7  segment bus, bit order g..a = [6:0].
REQ-008 digit_sel  input  NUM_DIGITS  digit-select strobes; bit i selects digit i.
REQ-009 error_clear  input  1  synchronous clear of pattern_error.
REQ-010 value  output  4*NUM_DIGITS  decoded frame; digit i in bits [4i+3:4i].
REQ-011 blank_mask  output  NUM_DIGITS  bit i set when digit i was blank in the captured frame.
REQ-012 frame_valid  output  1  single-cycle pulse when value/blank_mask update.
REQ-013 pattern_error  output  1  sticky flag for an unrecognised segment pattern.

Function
REQ-014 seg_in and digit_sel SHALL pass through a two-flop synchroniser, then be normalised to active-high per INVERT_SEG/INVERT_SEL.
REQ-015 Decode table (active-high gfedcba): 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 1110111=A, 1111100=b, 0111001=C, 1011110=d, 1111001=E, 1110001=F, 0000000=blank (nibble 0, blank bit set); any other pattern is invalid.
REQ-016 Stability counter SHALL increment each cycle the normalised (sel,seg) sample equals the previous cycle's sample, SHALL reset to 0 on any difference, and SHALL saturate at STABLE_CYCLES.
REQ-017 A commit SHALL occur on the single cycle the counter transitions to STABLE_CYCLES-1 (sample unchanged for STABLE_CYCLES cycles); at most one commit per dwell.
REQ-018 A commit SHALL be suppressed when the normalised select is zero or not one-hot; the counter still runs.
REQ-019 Valid commit: nibble and blank bit written to digit-i shadow register, seen[i] set.
REQ-020 Invalid-pattern commit: pattern_error set, shadow unchanged, seen[i] cleared.
REQ-021 When a commit makes seen all-ones, the next cycle SHALL load value/blank_mask from the shadow, pulse frame_valid for one cycle, and clear seen.
REQ-022 Re-commit of an already-seen digit before frame completion SHALL overwrite its shadow entry (latest wins).
REQ-023 Latency: frame_valid asserts exactly STABLE_CYCLES+3 cycles after the final digit's inputs settle at the pins.
REQ-024 error_clear SHALL clear pattern_error next cycle; a simultaneous invalid commit SHALL win (flag stays set).
REQ-025 value and blank_mask SHALL hold between frame_valid pulses.

Reset
REQ-026 reset_n low SHALL asynchronously clear synchronisers, counter, shadow, seen, value, blank_mask, frame_valid and pattern_error to 0.
REQ-027 Reset mid-frame SHALL discard partial frames; no frame_valid until a full new frame after release.

Structure
REQ-028 Shared package SHALL hold the 7-bit pattern constants and the nibble/blank decode function, shared with the display encoder.
REQ-029 One sub-module seven_seg_decode: combinational 7-bit pattern -> {valid, blank, nibble}.

Verification
REQ-030 Active-low drive of digits 3..0 = 1,2,3,4, each held 8 cycles -> one frame_valid, value=16'h1234, blank_mask=0000.
REQ-031 Digit held only STABLE_CYCLES-1 cycles -> no commit, no frame_valid.
REQ-032 Segments 1000000 on digit 2 -> pattern_error=1, no frame until digit 2 recaptured validly; error_clear then drops it.
REQ-033 digit_sel=0011 held 10 cycles -> no commit; digit_sel=0000 likewise.
REQ-034 reset_n pulsed low after digits 0,1 committed -> outputs 0; next full frame F,E,blank,A -> value=16'hF00A? No: digit3=F,digit2=E,digit1=blank,digit0=A -> value=16'hFE0A, blank_mask=0010.
REQ-035 Invalid commit coincident with error_clear -> pattern_error remains 1.

Source files
------------

// File: rtl/seven_seg_capture_pkg.sv
// rtl/seven_seg_capture_pkg.sv - seven-segment pattern constants and decode function
// Purpose: active-high gfedcba patterns for hex digits and blank, plus the
// pattern -> {valid, blank, nibble} decode shared with the display encoder.
// Ports: none (package).
package seven_seg_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_decode_t;

  // Blank decodes as a valid digit with nibble 0 and the blank bit set.
  function automatic seg_decode_t decode_seg(input logic [6:0] pattern);
    seg_decode_t r;
    r.valid  = 1'b1;
    r.blank  = 1'b0;
    r.nibble = 4'h0;
    case (pattern)
      SEG_0:     r.nibble = 4'h0;
      SEG_1:     r.nibble = 4'h1;
      SEG_2:     r.nibble = 4'h2;
      SEG_3:     r.nibble = 4'h3;
      SEG_4:     r.nibble = 4'h4;
      SEG_5:     r.nibble = 4'h5;
      SEG_6:     r.nibble = 4'h6;
      SEG_7:     r.nibble = 4'h7;
      SEG_8:     r.nibble = 4'h8;
      SEG_9:     r.nibble = 4'h9;
      SEG_A:     r.nibble = 4'hA;
      SEG_B:     r.nibble = 4'hB;
      SEG_C:     r.nibble = 4'hC;
      SEG_D:     r.nibble = 4'hD;
      SEG_E:     r.nibble = 4'hE;
      SEG_F:     r.nibble = 4'hF;
      SEG_BLANK: r.blank  = 1'b1;
      default:   r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - combinational seven-segment pattern decoder
// Purpose: map an active-high gfedcba pattern to {valid, blank, nibble}.
// Ports: seg (in, 7) pattern; valid/blank (out) flags; nibble (out, 4) digit value.
module seven_seg_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  seg_decode_t dec;

  assign dec    = decode_seg(seg);
  assign valid  = dec.valid;
  assign blank  = dec.blank;
  assign nibble = dec.nibble;

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - captures a multiplexed seven-segment display into a hex frame
// Purpose: synchronise and normalise segment/select pins, accept each digit after a
// stable dwell, assemble a frame and publish it once every digit has been seen.
// Ports: clock, reset_n (async active-low); seg_in (7) segments g..a; digit_sel
// (NUM_DIGITS) strobes; error_clear clears pattern_error; value (4*NUM_DIGITS) frame;
// blank_mask (NUM_DIGITS) blank digits; frame_valid one-cycle update pulse;
// pattern_error sticky unrecognised-pattern flag.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter bit INVERT_SEG    = 1'b1,
  parameter bit INVERT_SEL    = 1'b1,
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    error_clear,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_valid,
  output logic                    pattern_error
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
  // Commit fires on the edge the counter moves from STABLE_CYCLES-2 to STABLE_CYCLES-1.
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 2);

  logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, prev_seg_q, prev_seg_d;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, prev_sel_q, prev_sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    err_q, err_d;

  logic [6:0]              seg_norm;
  logic [NUM_DIGITS-1:0]   sel_norm;
  logic                    same, commit;
  logic                    dec_valid, dec_blank;
  logic [3:0]              dec_nibble;

  assign seg_norm = seg_s2_q ^ {7{INVERT_SEG}};
  assign sel_norm = sel_s2_q ^ {NUM_DIGITS{INVERT_SEL}};

  seven_seg_decode u_decode (
    .seg    (seg_norm),
    .valid  (dec_valid),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  assign same   = (seg_norm == prev_seg_q) && (sel_norm == prev_sel_q);
  // The counter keeps running for bad selects; only the commit is suppressed.
  assign commit = same && (cnt_q == CNT_COMMIT) && $onehot(sel_norm);

  always_comb begin
    seg_s1_d       = seg_in;
    seg_s2_d       = seg_s1_q;
    sel_s1_d       = digit_sel;
    sel_s2_d       = sel_s1_q;
    prev_seg_d     = seg_norm;
    prev_sel_d     = sel_norm;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    seen_d         = seen_q;
    value_d        = value_q;
    blank_d        = blank_q;
    frame_valid_d  = 1'b0;

    if (!same) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_norm[i]) begin
          if (dec_valid) begin
            shadow_d[4*i +: 4] = dec_nibble;
            shadow_blank_d[i]  = dec_blank;
            seen_d[i]          = 1'b1;
          end else begin
            seen_d[i] = 1'b0;
          end
        end
      end
    end

    // seen went all-ones on the previous edge: publish the frame and start over.
    if (&seen_q) begin
      value_d       = shadow_q;
      blank_d       = shadow_blank_q;
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end

    err_d = error_clear ? 1'b0 : err_q;
    if (commit && !dec_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q       <= '0;
      seg_s2_q       <= '0;
      sel_s1_q       <= '0;
      sel_s2_q       <= '0;
      prev_seg_q     <= '0;
      prev_sel_q     <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      seen_q         <= '0;
      value_q        <= '0;
      blank_q        <= '0;
      frame_valid_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      seg_s1_q       <= seg_s1_d;
      seg_s2_q       <= seg_s2_d;
      sel_s1_q       <= sel_s1_d;
      sel_s2_q       <= sel_s2_d;
      prev_seg_q     <= prev_seg_d;
      prev_sel_q     <= prev_sel_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      seen_q         <= seen_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      frame_valid_q  <= frame_valid_d;
      err_q          <= err_d;
    end
  end

  assign value         = value_q;
  assign blank_mask    = blank_q;
  assign frame_valid   = frame_valid_q;
  assign pattern_error = err_q;

endmodule
